// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the DIV/DIVU sequencer.
//   div_state_t  : FSM encodings (DIV_IDLE / DIV_RUN / DIV_DONE)
//   DIV_ZERO_LO  : quotient reported when the divisor is zero
//   FUNCT_DIV/U  : EX funct codes; FUNCT_DIV selects signed division
package div_sequencer_pkg;

   localparam int DATA_W  = 32;
   localparam int FUNCT_W = 6;

   localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 6'b011010;
   localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 6'b011011;

   localparam logic [DATA_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divide sequencer handshake.
//   master : EX side, drives start/funct/operands/annul, sees results
//   slave  : sequencer side
//   start, funct, operand_1 (dividend), operand_2 (divisor), annul
//   stall_req, done, hi (remainder), lo (quotient), div_zero
interface div_sequencer_if
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic               start;
   logic [FUNCT_W-1:0] funct;
   logic [WIDTH-1:0]   operand_1;
   logic [WIDTH-1:0]   operand_2;
   logic               annul;
   logic               stall_req;
   logic               done;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               div_zero;

   modport master (
      output start, funct, operand_1, operand_2, annul,
      input  stall_req, done, hi, lo, div_zero
   );

   modport slave (
      input  start, funct, operand_1, operand_2, annul,
      output stall_req, done, hi, lo, div_zero
   );
endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division step (combinational).
//   rem      : partial remainder, always < dvs
//   dvd_msb  : next dividend bit shifted into the remainder
//   dvs      : divisor magnitude
//   next_rem : remainder after the conditional subtract
//   q_bit    : quotient bit produced by this step
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // The shifted remainder can reach WIDTH+1 bits, so compare at full width.
   // When it is >= dvs the true difference is < dvs, so the low WIDTH bits
   // of the subtraction are exact.
   assign shifted  = {rem, dvd_msb};
   assign q_bit    = (shifted >= {1'b0, dvs});
   assign diff     = shifted[WIDTH-1:0] - dvs;
   assign next_rem = q_bit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the EX stage (restoring division,
// one quotient bit per cycle). Stalls IF..EX until hi/lo are ready.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : div_sequencer_if slave (start/funct/operands/annul in,
//              stall_req/done/hi/lo/div_zero out)
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   div_sequencer_if.slave  bus
);
   div_state_t       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] dvd;     // dividend magnitude, shifted out MSB first
   logic [WIDTH-1:0] dvs;     // divisor magnitude
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             div_zero_q;

   logic             is_signed;
   logic             accept;
   logic [WIDTH-1:0] mag_1, mag_2;
   logic [WIDTH-1:0] next_rem;
   logic             q_bit;
   logic [WIDTH-1:0] q_final;

   assign is_signed = (bus.funct == FUNCT_DIV);
   assign accept    = (state == DIV_IDLE) && bus.start && !bus.annul;

   // Magnitudes are only taken for signed division; 0x8000_0000 maps to itself,
   // which is the correct unsigned magnitude.
   assign mag_1 = (is_signed && bus.operand_1[WIDTH-1]) ? ~bus.operand_1 + 1'b1 : bus.operand_1;
   assign mag_2 = (is_signed && bus.operand_2[WIDTH-1]) ? ~bus.operand_2 + 1'b1 : bus.operand_2;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .dvd_msb  (dvd[WIDTH-1]),
      .dvs      (dvs),
      .next_rem (next_rem),
      .q_bit    (q_bit)
   );

   assign q_final = {quo[WIDTH-2:0], q_bit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= DIV_IDLE;
         count      <= '0;
         dvd        <= '0;
         dvs        <= '0;
         rem        <= '0;
         quo        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (accept) begin
                  if (bus.operand_2 == '0) begin
                     hi_q       <= bus.operand_1;
                     lo_q       <= DIV_ZERO_LO;
                     div_zero_q <= 1'b1;
                     state      <= DIV_DONE;
                  end else begin
                     dvd        <= mag_1;
                     dvs        <= mag_2;
                     neg_q      <= is_signed && (bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1]);
                     neg_r      <= is_signed && bus.operand_1[WIDTH-1];
                     count      <= '0;
                     rem        <= '0;
                     quo        <= '0;
                     div_zero_q <= 1'b0;
                     state      <= DIV_RUN;
                  end
               end
            end
            DIV_RUN: begin
               if (bus.annul) begin
                  state <= DIV_IDLE;
               end else begin
                  rem   <= next_rem;
                  dvd   <= {dvd[WIDTH-2:0], 1'b0};
                  quo   <= q_final;
                  count <= count + 1'b1;
                  // Last step: fold the sign fix into the result registers.
                  if (count == CNT_W'(WIDTH - 1)) begin
                     lo_q  <= neg_q ? ~q_final + 1'b1 : q_final;
                     hi_q  <= neg_r ? ~next_rem + 1'b1 : next_rem;
                     state <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

   assign bus.stall_req = accept || (state == DIV_RUN);
   assign bus.done      = (state == DIV_DONE);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.div_zero  = div_zero_q;
endmodule
